blink_io: RTL and testbench



---
 rtl/blink_io.sv | 177 +++++++++++++++++
 tb/tb_blink_io.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_io.sv
// blink_io: Z88 Blink I/O-side responder with bank/COM registers, RTC and interrupt request.
// Optional RTC block (prescaler, TIM0-TIM4, TSTA/TMK/TACK) is built when BLINK_RTC_EN is defined.
module blink_io #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] a,
  input  logic [7:0] di,
  output logic [7:0] do_o,
  output logic       do_en,
  output logic [7:0] sr0,
  output logic [7:0] sr1,
  output logic [7:0] sr2,
  output logic [7:0] sr3,
  output logic [7:0] com,
  output logic       int_n
);

  // Bus cycles: an I/O cycle is iorq_n=0 with m1_n=1 (m1_n=0 is an interrupt
  // acknowledge and is ignored). A write commits once, on the first edge the
  // write strobe is seen; reads are answered combinationally while rd_n=0.
  logic io_cyc, wr_cond, rd_cond, wr_commit;
  logic wr_prev_q;
  logic [7:0] sr0_q, sr1_q, sr2_q, sr3_q, com_q, int_q;
  logic sta_bit;

  assign io_cyc    = ~iorq_n & m1_n;
  assign wr_cond   = io_cyc & ~wr_n;
  assign rd_cond   = io_cyc & ~rd_n;
  assign wr_commit = wr_cond & ~wr_prev_q;

  // Previous state resets to "active" so a write spanning reset release never commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_prev_q <= 1'b1;
    else       wr_prev_q <= wr_cond;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr0_q <= '0;
      sr1_q <= '0;
      sr2_q <= '0;
      sr3_q <= '0;
      com_q <= '0;
      int_q <= '0;
    end else if (wr_commit) begin
      case (a)
        8'hB0:   com_q <= di;
        8'hB1:   int_q <= di;
        8'hD0:   sr0_q <= di;
        8'hD1:   sr1_q <= di;
        8'hD2:   sr2_q <= di;
        8'hD3:   sr3_q <= di;
        default: ;
      endcase
    end
  end

  assign sr0 = sr0_q;
  assign sr1 = sr1_q;
  assign sr2 = sr2_q;
  assign sr3 = sr3_q;
  assign com = com_q;

`ifdef BLINK_RTC_EN
  localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  tim0_q, tim0_d;
  logic [5:0]  tim1_q, tim1_d;
  logic [20:0] min_q, min_d;
  logic [2:0]  tsta_q, tsta_d, tmk_q, ack;
  logic [7:0]  sh1_q, sh2_q, sh3_q;
  logic [4:0]  sh4_q;
  logic        restim, tick, sec, min_ev, rd_d0, rd_d0_q, snap;
  logic        unused_bits;

  assign unused_bits = &{1'b0, int_q[7:2]};
  assign rd_d0 = rd_cond & (a == 8'hD0);
  assign snap  = rd_d0 & ~rd_d0_q;

  always_comb begin
    restim  = com_q[4];
    tick    = ~restim & (presc_q == TICK_MAX);
    sec     = tick & (tim0_q == 8'd199);
    min_ev  = sec & (tim1_q == 6'd59);
    presc_d = tick ? '0 : presc_q + 16'd1;
    tim0_d  = sec ? '0 : (tick ? tim0_q + 8'd1 : tim0_q);
    tim1_d  = min_ev ? '0 : (sec ? tim1_q + 6'd1 : tim1_q);
    min_d   = min_ev ? min_q + 21'd1 : min_q;
    if (restim) begin
      presc_d = '0;
      tim0_d  = '0;
      tim1_d  = '0;
      min_d   = '0;
    end
    // New events are ORed in after the acknowledge so a same-edge set wins.
    ack    = (wr_commit && a == 8'hB4) ? di[2:0] : 3'b000;
    tsta_d = (tsta_q & ~ack) | {min_ev, sec, tick};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tim0_q  <= '0;
      tim1_q  <= '0;
      min_q   <= '0;
      tsta_q  <= '0;
      tmk_q   <= '0;
      rd_d0_q <= 1'b0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
      sh4_q   <= '0;
    end else begin
      presc_q <= presc_d;
      tim0_q  <= tim0_d;
      tim1_q  <= tim1_d;
      min_q   <= min_d;
      tsta_q  <= tsta_d;
      rd_d0_q <= rd_d0;
      if (wr_commit && a == 8'hB5) tmk_q <= di[2:0];
      if (snap) begin
        sh1_q <= {2'b00, tim1_q};
        sh2_q <= min_q[7:0];
        sh3_q <= min_q[15:8];
        sh4_q <= min_q[20:16];
      end
    end
  end

  assign sta_bit = |(tsta_q & tmk_q);
  assign int_n   = ~(int_q[0] & int_q[1] & sta_bit);

  always_comb begin
    do_o  = 8'h00;
    do_en = 1'b0;
    if (rd_cond) begin
      case (a)
        8'hB1: begin do_o = {7'b0, sta_bit};  do_en = 1'b1; end
        8'hB5: begin do_o = {5'b0, tsta_q};   do_en = 1'b1; end
        8'hD0: begin do_o = tim0_q;           do_en = 1'b1; end
        8'hD1: begin do_o = sh1_q;            do_en = 1'b1; end
        8'hD2: begin do_o = sh2_q;            do_en = 1'b1; end
        8'hD3: begin do_o = sh3_q;            do_en = 1'b1; end
        8'hD4: begin do_o = {3'b000, sh4_q};  do_en = 1'b1; end
        default: ;
      endcase
    end
  end
`else
  logic unused_bits;

  assign unused_bits = &{1'b0, int_q, 16'(TICK_DIV)};
  assign sta_bit     = 1'b0;
  assign int_n       = 1'b1;

  // Without the RTC the timer ports still answer, always with zero.
  always_comb begin
    do_o  = 8'h00;
    do_en = 1'b0;
    if (rd_cond) begin
      case (a)
        8'hB1:                                    begin do_o = {7'b0, sta_bit}; do_en = 1'b1; end
        8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4: do_en = 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_blink_io.sv
// Bench for blink_io: randomized bus traffic checked against an elapsed-cycle RTC model.
module tb_blink_io;
  localparam int TD = 4;

  logic       clk, reset, iorq_n, m1_n, rd_n, wr_n;
  logic [7:0] a, di, do_o, sr0, sr1, sr2, sr3, com;
  logic       do_en, int_n;

  int     n_vec = 0;
  int     n_err = 0;
  longint edge_n = 0;

  // Reference model state
  logic [7:0] m_sr[4];
  logic [7:0] m_com, m_int, m_sh1, m_sh2, m_sh3, m_sh4;
  logic [2:0] m_tmk;
  bit         m_restim;
  longint     rel_e, set_e;
  longint     base[3];
  longint     ack_tot[3];
  logic [8:0] exp_q[$];

  blink_io #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .a(a), .di(di), .do_o(do_o), .do_en(do_en),
    .sr0(sr0), .sr1(sr1), .sr2(sr2), .sr3(sr3), .com(com), .int_n(int_n)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model: counters are derived from edges elapsed since RESTIM last released.
  function automatic longint divk(input int k);
    if (k == 0) return longint'(TD);
    else if (k == 1) return longint'(TD) * 200;
    else return longint'(TD) * 12000;
  endfunction

  function automatic longint cnt_n(input longint e);
    if (m_restim && e > set_e) return 0;
    return (e > rel_e) ? e - rel_e : 0;
  endfunction

  function automatic longint total(input int k, input longint e);
    if (m_restim) return base[k];
    return base[k] + ((e > rel_e) ? (e - rel_e) / divk(k) : 0);
  endfunction

  function automatic logic [2:0] m_tsta(input longint e);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = (total(k, e) > ack_tot[k]);
    return r;
  endfunction

  function automatic logic [7:0] m_tim0(input longint e);
    return 8'((cnt_n(e) / TD) % 200);
  endfunction

  function automatic logic [7:0] m_tim1(input longint e);
    return 8'(((cnt_n(e) / TD) / 200) % 60);
  endfunction

  function automatic logic [20:0] m_minute(input longint e);
    return 21'((cnt_n(e) / TD) / 12000);
  endfunction

  function automatic logic exp_int_n(input longint e);
`ifdef BLINK_RTC_EN
    return ~(m_int[0] & m_int[1] & |(m_tsta(e) & m_tmk));
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [8:0] exp_rd(input logic [7:0] p, input longint e);
`ifdef BLINK_RTC_EN
    logic [2:0] ts;
    ts = m_tsta(e);
    case (p)
      8'hB1:   return {1'b1, 7'b0, |(ts & m_tmk)};
      8'hB5:   return {1'b1, 5'b0, ts};
      8'hD0:   return {1'b1, m_tim0(e)};
      8'hD1:   return {1'b1, m_sh1};
      8'hD2:   return {1'b1, m_sh2};
      8'hD3:   return {1'b1, m_sh3};
      8'hD4:   return {1'b1, m_sh4};
      default: return 9'h000;
    endcase
`else
    case (p)
      8'hB1, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4: return 9'h100;
      default: return 9'h000;
    endcase
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_sr[i] = 8'h00;
    m_com = 8'h00; m_int = 8'h00; m_tmk = 3'b000;
    m_sh1 = 8'h00; m_sh2 = 8'h00; m_sh3 = 8'h00; m_sh4 = 8'h00;
    m_restim = 1'b0; rel_e = edge_n; set_e = 0;
    for (int k = 0; k < 3; k++) begin base[k] = 0; ack_tot[k] = 0; end
  endtask

  task automatic model_write(input logic [7:0] p, input logic [7:0] d, input longint ce);
    case (p)
      8'hB0: begin
        if (!m_restim && d[4]) begin
          for (int k = 0; k < 3; k++) base[k] = total(k, ce);
          set_e = ce;
          m_restim = 1'b1;
        end else if (m_restim && !d[4]) begin
          rel_e = ce;
          m_restim = 1'b0;
        end
        m_com = d;
      end
      8'hB1: m_int = d;
`ifdef BLINK_RTC_EN
      8'hB4: for (int k = 0; k < 3; k++) if (d[k]) ack_tot[k] = total(k, ce - 1);
      8'hB5: m_tmk = d[2:0];
`endif
      8'hD0: m_sr[0] = d;
      8'hD1: m_sr[1] = d;
      8'hD2: m_sr[2] = d;
      8'hD3: m_sr[3] = d;
      default: ;
    endcase
  endtask

  task automatic model_snapshot(input longint e);
`ifdef BLINK_RTC_EN
    logic [20:0] mn;
    mn = m_minute(e);
    m_sh1 = m_tim1(e);
    m_sh2 = mn[7:0];
    m_sh3 = mn[15:8];
    m_sh4 = {3'b000, mn[20:16]};
`endif
  endtask

  // Driver tasks: called at a falling edge, return at a falling edge.
  task automatic io_write(input logic [7:0] p, input logic [7:0] d, input int hold);
    a = p; di = d; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    model_write(p, d, edge_n);
    repeat (hold - 1) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] p, output logic [7:0] d, output logic en,
                         output logic [8:0] ex);
    a = p; m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = do_o; en = do_en; ex = exp_rd(p, edge_n);
    @(negedge clk);
    if (p == 8'hD0) model_snapshot(edge_n - 1);
    iorq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a = 8'h00; di = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_vec++; if ({sr0, sr1, sr2, sr3, com} !== 40'h0) begin
      n_err++; $display("FAIL reset_regs: got %h expected 0", {sr0, sr1, sr2, sr3, com}); end
    n_vec++; if ({do_en, do_o, int_n} !== 10'b0_00000000_1) begin
      n_err++; $display("FAIL reset_outs: got en=%b do=%h int_n=%b expected 0/00/1", do_en, do_o, int_n); end
    io_write(8'hD0, 8'hAA, 1);
    n_vec++; if (sr0 !== 8'hAA) begin n_err++; $display("FAIL pre_reset_sr0: got %h expected aa", sr0); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (sr0 !== 8'h00) begin n_err++; $display("FAIL async_reset_sr0: got %h expected 00", sr0); end
    @(negedge clk);
    a = 8'hD3; di = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    n_vec++; if (sr3 !== 8'h00) begin n_err++; $display("FAIL write_across_reset sr3: got %h expected 00", sr3); end
  endtask

  task automatic test_bank();
    io_write(8'hD2, 8'h5A, 1);
    io_write(8'hD0, 8'h81, 1);
    io_write(8'hB0, 8'h04, 1);
    n_vec++; if (sr2 !== 8'h5A) begin n_err++; $display("FAIL bank_sr2: got %h expected 5a", sr2); end
    n_vec++; if (sr0 !== 8'h81) begin n_err++; $display("FAIL bank_sr0: got %h expected 81", sr0); end
    n_vec++; if (com !== 8'h04) begin n_err++; $display("FAIL bank_com: got %h expected 04", com); end
    n_vec++; if ({sr1, sr3} !== 16'h0) begin n_err++; $display("FAIL bank_sr1_sr3: got %h expected 0000", {sr1, sr3}); end
  endtask

  task automatic test_write_commit();
    a = 8'hD1; di = 8'h33; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    #1;
    n_vec++; if (sr1 !== 8'h00) begin n_err++; $display("FAIL before_commit sr1: got %h expected 00", sr1); end
    @(negedge clk);
    model_write(8'hD1, 8'h33, edge_n);
    n_vec++; if (sr1 !== 8'h33) begin n_err++; $display("FAIL commit_latency sr1: got %h expected 33", sr1); end
    di = 8'h44;
    repeat (4) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    n_vec++; if (sr1 !== 8'h33) begin n_err++; $display("FAIL single_commit sr1: got %h expected 33", sr1); end
    // Interrupt acknowledge: neither reads nor writes respond
    a = 8'hD1; di = 8'h77; m1_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    n_vec++; if (do_en !== 1'b0) begin n_err++; $display("FAIL im2_read do_en: got %b expected 0", do_en); end
    @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    @(negedge clk);
    n_vec++; if (sr1 !== 8'h33) begin n_err++; $display("FAIL im2_write sr1: got %h expected 33", sr1); end
  endtask

  task automatic test_random();
    logic [7:0] wports[9] = '{8'hB0, 8'hB1, 8'hB4, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h00};
    logic [7:0] rports[9] = '{8'hB1, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h42, 8'h00};
    logic [7:0] p, d, rd;
    logic [7:0] got_sr[4];
    logic       en;
    logic [8:0] ex, e;
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          p = wports[$urandom_range(0, 8)];
          if (p == 8'h00) p = 8'($urandom);
          d = 8'($urandom);
          if (p == 8'hB0 && $urandom_range(0, 3) != 0) d[4] = 1'b0;
          io_write(p, d, int'($urandom_range(1, 3)));
          got_sr = '{sr0, sr1, sr2, sr3};
          for (int i = 0; i < 4; i++) begin
            n_vec++; if (got_sr[i] !== m_sr[i]) begin
              n_err++; $display("FAIL rand_sr%0d: got %h expected %h", i, got_sr[i], m_sr[i]); end
          end
          n_vec++; if (com !== m_com) begin n_err++; $display("FAIL rand_com: got %h expected %h", com, m_com); end
        end
        1: begin
          p = rports[$urandom_range(0, 8)];
          if (p == 8'h00) p = 8'($urandom);
          io_read(p, rd, en, ex);
          exp_q.push_back(ex);
          e = exp_q.pop_front();
          n_vec++; if ({en, rd} !== e) begin
            n_err++; $display("FAIL rand_read port %h: got en=%b do=%h expected en=%b do=%h", p, en, rd, e[8], e[7:0]); end
        end
        default: repeat ($urandom_range(1, 6)) @(negedge clk);
      endcase
      n_vec++; if (int_n !== exp_int_n(edge_n)) begin
        n_err++; $display("FAIL rand_int_n: got %b expected %b", int_n, exp_int_n(edge_n)); end
    end
  endtask

`ifdef BLINK_RTC_EN
  task automatic test_tick();
    logic [7:0] rd;
    logic       en;
    logic [8:0] ex;
    io_write(8'hB0, 8'h10, 1);
    io_write(8'hB0, 8'h00, 1);
    while (edge_n < rel_e + 4) @(negedge clk);
    io_read(8'hD0, rd, en, ex);
    n_vec++; if ({en, rd} !== 9'h101 || ex !== 9'h101) begin
      n_err++; $display("FAIL tim0_first_tick: got %h expected 01 (model %h)", rd, ex[7:0]); end
    while (edge_n < rel_e + 800) @(negedge clk);
    io_read(8'hD0, rd, en, ex);
    n_vec++; if (rd !== 8'h00 || rd !== ex[7:0]) begin n_err++; $display("FAIL tim0_wrap: got %h expected 00", rd); end
    io_read(8'hD0, rd, en, ex);
    io_read(8'hD1, rd, en, ex);
    n_vec++; if (rd !== 8'h01 || rd !== ex[7:0]) begin n_err++; $display("FAIL tim1_after_sec: got %h expected 01", rd); end
    io_read(8'hB5, rd, en, ex);
    n_vec++; if (rd[1] !== 1'b1 || {en, rd} !== ex) begin
      n_err++; $display("FAIL tsta_sec: got %h expected bit1 set (model %h)", rd, ex[7:0]); end
  endtask

  task automatic test_interrupt();
    logic [7:0] rd;
    logic       en;
    logic [8:0] ex;
    io_write(8'hB5, 8'h01, 1);
    io_write(8'hB1, 8'h03, 1);
    while ((cnt_n(edge_n + 1) % TD) != 1) @(negedge clk);
    io_write(8'hB4, 8'h01, 1);
    while ((cnt_n(edge_n) % TD) != 0) begin
      n_vec++; if (int_n !== 1'b1) begin n_err++; $display("FAIL int_after_tack: got %b expected 1", int_n); end
      @(negedge clk);
    end
    n_vec++; if (int_n !== 1'b0) begin n_err++; $display("FAIL int_on_tick: got %b expected 0", int_n); end
    while ((cnt_n(edge_n + 1) % TD) != 0) @(negedge clk);
    io_write(8'hB4, 8'h01, 1);
    n_vec++; if (int_n !== 1'b0) begin n_err++; $display("FAIL tack_on_tick int_n: got %b expected 0", int_n); end
    io_read(8'hB5, rd, en, ex);
    n_vec++; if (rd[0] !== 1'b1 || {en, rd} !== ex) begin
      n_err++; $display("FAIL tack_on_tick tsta: got %h expected bit0 set (model %h)", rd, ex[7:0]); end
  endtask

  task automatic test_time_read();
    logic [7:0] rd;
    logic [7:0] want[4] = '{8'h3B, 8'h00, 8'h00, 8'h00};
    logic       en;
    logic [8:0] ex;
    io_write(8'hB0, 8'h10, 1);
    io_write(8'hB0, 8'h00, 1);
    while (edge_n < rel_e + 47992) @(negedge clk);
    io_read(8'hD0, rd, en, ex);
    n_vec++; if ({en, rd} !== ex) begin n_err++; $display("FAIL tim0_live: got %h expected %h", rd, ex[7:0]); end
    while (edge_n < rel_e + 48010) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      io_read(8'hD1 + 8'(i), rd, en, ex);
      n_vec++; if ({en, rd} !== {1'b1, want[i]} || ex !== {1'b1, want[i]}) begin
        n_err++; $display("FAIL shadow_tim%0d: got %h expected %h", i + 1, rd, want[i]); end
    end
    io_read(8'hD0, rd, en, ex);
    io_read(8'hD2, rd, en, ex);
    n_vec++; if (rd !== 8'h01 || {en, rd} !== ex) begin n_err++; $display("FAIL minute_tim2: got %h expected 01", rd); end
    io_write(8'hB0, 8'h10, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      io_read(8'hD0, rd, en, ex);
      n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL restim_tim0: got %h expected 00", rd); end
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      io_read(8'hD1 + 8'(i), rd, en, ex);
      n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL restim_tim%0d: got %h expected 00", i + 1, rd); end
    end
  endtask
`else
  task automatic test_macro_off();
    logic [7:0] rd;
    logic       en;
    logic [8:0] ex;
    io_read(8'hB5, rd, en, ex);
    n_vec++; if ({en, rd} !== 9'h100) begin n_err++; $display("FAIL off_b5: got en=%b do=%h expected 1/00", en, rd); end
    for (int i = 0; i < 5; i++) begin
      io_read(8'hD0 + 8'(i), rd, en, ex);
      n_vec++; if ({en, rd} !== 9'h100) begin
        n_err++; $display("FAIL off_d%0d: got en=%b do=%h expected 1/00", i, en, rd); end
    end
    io_write(8'hB1, 8'h03, 1);
    io_write(8'hB5, 8'h07, 1);
    io_write(8'hB4, 8'hFF, 1);
    for (int i = 0; i < 30; i++) begin
      n_vec++; if (int_n !== 1'b1) begin n_err++; $display("FAIL off_int_n: got %b expected 1", int_n); end
      @(negedge clk);
    end
    io_read(8'hB1, rd, en, ex);
    n_vec++; if ({en, rd} !== 9'h100) begin n_err++; $display("FAIL off_sta: got en=%b do=%h expected 1/00", en, rd); end
    io_read(8'h42, rd, en, ex);
    n_vec++; if ({en, rd} !== 9'h000) begin n_err++; $display("FAIL off_port42: got en=%b do=%h expected 0/00", en, rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_bank();
    test_write_commit();
`ifdef BLINK_RTC_EN
    test_tick();
    test_interrupt();
    test_random();
    test_time_read();
`else
    test_macro_off();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
